// File: rtl/offset_gen.sv
// Immediate extractor/extender feeding the offset operand latch through a 2-entry valid/ready buffer.
// Optional build macro OFFSET_HALFWORD_SCALE_EN: formats 00 and 10 are shifted left by one after extension.
module offset_gen #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic [1:0]       fmt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] offset_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       accept_cnt
);

    logic [1:0]       count_reg, count_next;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic [WIDTH-1:0] entry_reg [DEPTH];
    logic [7:0]       accept_cnt_reg;
    logic [WIDTH-1:0] ext_value;
    logic             push, pop;

    // Upper instruction bits never carry immediate data.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[WIDTH-1:11];

    always_comb begin
        ext_value = '0;
        case (fmt)
            2'b00:   ext_value = {{8{instr[7]}}, instr[7:0]};
            2'b01:   ext_value = {{12{instr[3]}}, instr[3:0]};
            2'b10:   ext_value = {{5{instr[10]}}, instr[10:0]};
            default: ext_value = {8'h00, instr[7:0]};
        endcase
`ifdef OFFSET_HALFWORD_SCALE_EN
        if (fmt == 2'b00 || fmt == 2'b10)
            ext_value = {ext_value[WIDTH-2:0], 1'b0};
`endif
    end

    // Handshakes depend only on registered count, never on in_valid/out_ready.
    assign in_ready   = (count_reg != 2'(DEPTH));
    assign out_valid  = (count_reg != 2'd0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign offset_out = entry_reg[rd_ptr_reg];
    assign accept_cnt = accept_cnt_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg      <= 2'd0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            accept_cnt_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg     <= ~wr_ptr_reg;
                accept_cnt_reg <= accept_cnt_reg + 8'd1;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                entry_reg[gi] <= '0;
            else if (push && (wr_ptr_reg == 1'(gi)))
                entry_reg[gi] <= ext_value;
        end
    end

endmodule

// File: doc/offset_gen.md
Name: offset_gen

Overview:
- Producer side of the offset path: extracts the immediate field from a 16-bit instruction word, sign- or zero-extends it to 16 bits and presents it as the sign_ext8-style offset operand consumed by the offset/register-B latch.
- Sits between instruction decode and the operand register.
- Decouples the two with a 2-entry valid/ready buffer, so decode can run ahead by two offsets while the datapath stalls.

Parameters:
- WIDTH, 16, width of the instruction word and of the extended offset; the block is defined for 16 only and other values are out of scope.
- DEPTH, 2, buffer entries; fixed at 2 (skid-buffer depth), count is 2 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  16  instruction word carrying the immediate.
- fmt  input  2  immediate format select, sampled with instr.
- in_valid  input  1  instr/fmt valid this cycle.
- in_ready  output  1  block can accept; equals (count != 2).
- offset_out  output  16  head-of-buffer extended offset.
- out_valid  output  1  offset_out valid; equals (count != 0).
- out_ready  input  1  consumer takes offset_out this cycle.
- accept_cnt  output  8  number of offsets accepted since reset, wraps 255->0.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - count=0, write/read pointers=0, both storage entries=16'h0000, accept_cnt=0.
  - Hence out_valid=0, offset_out=16'h0000, in_ready=1.
  - Reset mid-transfer discards all buffered entries; there is no partial-state recovery.
- Extension is combinational on the input side; the stored value is already extended.
  - fmt=00, imm8 signed: {{8{instr[7]}}, instr[7:0]}.
  - fmt=01, imm4 signed: {{12{instr[3]}}, instr[3:0]}.
  - fmt=10, imm11 signed (jump): {{5{instr[10]}}, instr[10:0]}.
  - fmt=11, imm8 unsigned: {8'h00, instr[7:0]}.
- Push occurs when in_valid && in_ready at a rising edge.
  - The extended value is written at wr_ptr; wr_ptr toggles; accept_cnt increments.
- Pop occurs when out_valid && out_ready at a rising edge; rd_ptr toggles.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged (legal only when count==1; at count==2 in_ready=0, at count==0 out_valid=0).
- Latency: a value accepted at edge k appears on offset_out with out_valid=1 immediately after edge k, i.e. 1 cycle.
- Ordering is strict FIFO; offset_out always shows entry[rd_ptr].
- When count==0, offset_out shows the stale entry[rd_ptr] and the consumer must ignore it.
- Full (count==2): in_ready=0; in_valid is ignored and the producer must hold instr/fmt stable.
- Empty (count==0): out_valid=0; out_ready is ignored.
- in_ready and out_valid are derived from registered count only, with no combinational path from in_valid or out_ready.
- fmt/instr changes while in_valid=0 have no effect.

Optional Feature:
- Macro OFFSET_HALFWORD_SCALE_EN.
- Defined: formats 00 and 10 are shifted left by 1 after extension (16-bit result, MSB shifted out), for halfword-aligned branch targets.
  - Example: fmt=00, instr[7:0]=8'h80 -> 16'hFF00.
  - Formats 01 and 11 are unscaled.
- Undefined: no scaling on any format; 8'h80 with fmt=00 -> 16'hFF80.

Test Plan:
1. Reset check: assert rst_n=0 mid-run with 2 entries buffered -> out_valid=0, in_ready=1, offset_out=16'h0000 and accept_cnt=0 immediately, without waiting for a clock edge.
2. Format coverage, out_ready=1, macro undefined:
   - fmt=00, instr=16'h00F3 -> 16'hFFF3.
   - fmt=01, instr=16'h0008 -> 16'hFFF8; fmt=01, instr=16'h0007 -> 16'h0007.
   - fmt=10, instr=16'h0400 -> 16'hFC00.
   - fmt=11, instr=16'h00F3 -> 16'h00F3.
   - Each value appears 1 cycle after acceptance.
3. Backpressure: hold out_ready=0 and offer 3 words (8'h01, 8'h02, 8'h03, fmt=00).
   - After 2 accepts, in_ready=0 and the third word is held.
   - Raise out_ready -> outputs 16'h0001, 16'h0002, 16'h0003 in order, with no loss or duplication.
4. Streaming at count==1 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 1, one output per cycle, and accept_cnt advances by exactly 10.
5. accept_cnt wrap: 256 accepts -> accept_cnt returns to 8'h00.
6. With OFFSET_HALFWORD_SCALE_EN defined:
   - fmt=00, instr=16'h0080 -> 16'hFF00.
   - fmt=10, instr=16'h0001 -> 16'h0002.
   - fmt=01, instr=16'h000F -> 16'hFFFF (unscaled).
